// File: rtl/virtual_time_if.sv
// Handshake/data bundle for the virtual_time WFQ update block.
// master: the requester that supplies operands; slave: virtual_time itself.
interface virtual_time_if;
    logic        start;
    logic [15:0] delta_t;
    logic [15:0] sum_weight;
    logic [15:0] ovtime;
    logic        busy;
    logic        done;

    modport master (
        output start, delta_t, sum_weight,
        input  ovtime, busy, done
    );

    modport slave (
        input  start, delta_t, sum_weight,
        output ovtime, busy, done
    );
endinterface

// File: rtl/virtual_time.sv
// WFQ virtual-time accumulator: V += delta_t / sum_weight, using a radix-2
// restoring divider that produces one quotient bit per clock.
// Optional macro VTIME_FRAC_EN: 48-iteration divide producing a Q32.16
// increment, with a 16-bit fraction accumulator whose carry bumps ovtime.
// Default build: 32 iterations, integer increment, fraction discarded.
module virtual_time (
    input  logic          clk,
    input  logic          rst,
    virtual_time_if.slave bus
);

`ifdef VTIME_FRAC_EN
    localparam int unsigned QW = 48;
`else
    localparam int unsigned QW = 32;
`endif
    localparam logic [5:0] LAST = 6'(QW);

    typedef enum logic {IDLE, DIV} state_t;

    state_t          state, state_nxt;
    logic [5:0]      cnt;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [QW-1:0]   dq;
    logic [15:0]     divisor;
    logic [15:0]     rem;
    logic [15:0]     rem_nxt;
    logic [16:0]     trial;
    logic [16:0]     diff;
    logic            q_bit;
    logic [15:0]     inc;
    logic            carry;
    logic [15:0]     ovtime_r;
    logic            done_r;
`ifdef VTIME_FRAC_EN
    logic [15:0]     frac_acc;
    logic [15:0]     frac_inc;
    logic [16:0]     frac_sum;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: accept start only when idle, leave DIV after the final iteration
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DIV;
            DIV:     if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring-division step on the partial remainder
    always_comb begin
        trial   = {rem, dq[QW-1]};
        diff    = trial - {1'b0, divisor};
        q_bit   = (trial >= {1'b0, divisor});
        rem_nxt = q_bit ? diff[15:0] : trial[15:0];
    end

    // Saturated increment from the finished quotient; zero divisor adds nothing
    always_comb begin
        inc   = '0;
        carry = 1'b0;
`ifdef VTIME_FRAC_EN
        frac_inc = '0;
        if (divisor == '0) begin
            inc      = '0;
            frac_inc = '0;
        end else if (|dq[47:32]) begin
            inc      = '1;
            frac_inc = '1;
        end else begin
            inc      = dq[31:16];
            frac_inc = dq[15:0];
        end
        frac_sum = {1'b0, frac_acc} + {1'b0, frac_inc};
        carry    = frac_sum[16];
`else
        if (divisor == '0)    inc = '0;
        else if (|dq[31:16])  inc = '1;
        else                  inc = dq[15:0];
`endif
    end

    // Datapath: operand capture, iteration, and the accumulate/done edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dq       <= '0;
            divisor  <= '0;
            rem      <= '0;
            ovtime_r <= '0;
            done_r   <= 1'b0;
`ifdef VTIME_FRAC_EN
            frac_acc <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dq      <= {bus.delta_t, {(QW-16){1'b0}}};
                        divisor <= bus.sum_weight;
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                DIV: begin
                    if (cnt != LAST) begin
                        dq  <= {dq[QW-2:0], q_bit};
                        rem <= rem_nxt;
                        cnt <= cnt + 6'd1;
                    end else begin
                        ovtime_r <= ovtime_r + inc + {15'd0, carry};
                        done_r   <= 1'b1;
`ifdef VTIME_FRAC_EN
                        frac_acc <= frac_sum[15:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ovtime = ovtime_r;
    assign bus.busy   = (state == DIV);
    assign bus.done   = done_r;

endmodule

// File: tb/tb_virtual_time.sv
// Scoreboard bench for virtual_time: stimulus pushes expected ovtime and
// done cycle computed from plain arithmetic; a monitor pops on each done.
module tb_virtual_time;

`ifdef VTIME_FRAC_EN
    localparam int unsigned LAT   = 49;
    localparam int unsigned SHIFT = 32;
`else
    localparam int unsigned LAT   = 33;
    localparam int unsigned SHIFT = 16;
`endif

    typedef struct {
        int unsigned v;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rst;
    virtual_time_if bus ();

    virtual_time dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned busy_run = 0;
    exp_t        sb[$];

    longint unsigned model_v    = 0;
    longint unsigned model_facc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: V += min(floor(delta<<SHIFT / w) integer part, 0xFFFF), mod 2^16
    function automatic void model_update(input logic [15:0] d, input logic [15:0] w);
        longint unsigned q, ip, fr, ft;
        if (w == 16'd0) q = 0;
        else            q = (longint'(d) << SHIFT) / longint'(w);
`ifdef VTIME_FRAC_EN
        ip = q >> 16;
        fr = q & 64'hFFFF;
        if (ip > 65535) begin ip = 65535; fr = 65535; end
`else
        ip = q;
        fr = 0;
        if (ip > 65535) ip = 65535;
`endif
        ft         = model_facc + fr;
        model_v    = (model_v + ip + (ft >> 16)) % 65536;
        model_facc = ft % 65536;
    endfunction

    // Monitor: compares every done pulse against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ovtime", 32'(bus.ovtime), e.v);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_len", busy_run, LAT);
                end
                busy_run = 0;
            end
        end
    end

    // Issue one update at negedge+1; optionally hammer start/operands while busy
    task automatic run_op(input logic [15:0] d, input logic [15:0] w, input bit hammer);
        exp_t e;
        model_update(d, w);
        e.v   = 32'(model_v);
        e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
        bus.start      = 1'b1;
        bus.delta_t    = d;
        bus.sum_weight = w;
        @(negedge clk); #1;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int n = 0; n < int'(LAT) + 20 && sb.size() != 0; n++) begin
            bus.start      = hammer;
            bus.delta_t    = 16'($urandom);
            bus.sum_weight = 16'($urandom);
            @(negedge clk); #1;
        end
        bus.start = 1'b0;
        check("done_seen", sb.size(), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        sb.delete();
    endtask

    initial begin
        logic [15:0] d, w;
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.delta_t    = '0;
        bus.sum_weight = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ovtime", 32'(bus.ovtime), 32'd0);
        check("reset_busy",   32'(bus.busy),   32'd0);
        check("reset_done",   32'(bus.done),   32'd0);

        rst = 1'b1;
        run_op(16'd3, 16'h8000, 1'b0);
        run_op(16'd5, 16'hC000, 1'b0);
        run_op(16'd4, 16'h4000, 1'b0);
        run_op(16'd8, 16'hFFFF, 1'b0);
        run_op(16'd7, 16'h0000, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'd0, 16'h1234, 1'b0);
        run_op(16'd10, 16'h2000, 1'b1);

        // Abort a division partway through with an asynchronous reset
        sb.push_back('{v: 32'd0, cyc: 32'd0});
        bus.start      = 1'b1;
        bus.delta_t    = 16'd9;
        bus.sum_weight = 16'h1000;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ovtime", 32'(bus.ovtime), 32'd0);
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_done",   32'(bus.done),   32'd0);
        sb.delete();
        model_v    = 0;
        model_facc = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        run_op(16'd5, 16'hC000, 1'b0);
        run_op(16'd5, 16'hC000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) d = 16'd0;
            run_op(d, w, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/virtual_time.md
VIRTUAL_TIME -- requirements
Module: virtual_time

Interface
REQ-001 The block SHALL expose these ports: clk, input, 1, rising-edge clock for all state.
REQ-002 rst, input, 1: the block SHALL treat it as the asynchronous, active-low reset (one clock; reset asynchronous, active-low).
REQ-003 start, input, 1: the block SHALL treat it as the update request, sampled at the rising clk edge.
REQ-004 delta_t, input, 16: the block SHALL treat it as elapsed real time since the last update, unsigned integer.
REQ-005 sum_weight, input, 16: the block SHALL treat it as the sum of active-flow weights, unsigned Q0.16 (0x8000 = 0.5, 0xFFFF ≈ 1.0).
REQ-006 ovtime, output, 16: the block SHALL drive the current virtual time, unsigned integer, registered.
REQ-007 busy, output, 1: the block SHALL assert it while a division is in progress.
REQ-008 done, output, 1: the block SHALL pulse it for one cycle when ovtime is updated.

Function
REQ-009 The block SHALL implement the WFQ update V += delta_t / sum_weight, with increment = floor((delta_t << 16) / sum_weight).
REQ-010 Division SHALL be radix-2 restoring, one quotient bit per cycle: 32-bit dividend, 16-bit divisor, 32-bit quotient.
REQ-011 The block SHALL have two states: IDLE and DIV.
- IDLE -> DIV: on an edge with start=1; the same edge captures delta_t and sum_weight, clears the iteration counter and sets busy=1.
- DIV: runs 32 iteration edges.
- DIV -> IDLE: on the edge after the 32nd iteration (capture edge + 33); that edge updates ovtime, pulses done=1, and clears busy.
REQ-012 Latency SHALL be 33 cycles from the capture edge to the ovtime/done edge; a start seen on that same edge SHALL NOT be accepted (block is still in DIV); the earliest next capture is the following edge.
REQ-013 start asserted while busy=1 SHALL be ignored, and operand changes while busy SHALL NOT affect the result.
REQ-014 A 32-bit increment above 0xFFFF SHALL be saturated to 0xFFFF before accumulation.
REQ-015 ovtime SHALL accumulate modulo 2^16, i.e. wrap-around with no saturation of the sum.
REQ-016 With sum_weight = 0, the block SHALL still take 33 cycles and pulse done, and ovtime SHALL remain unchanged.
REQ-017 With delta_t = 0, the increment SHALL be 0, and done SHALL pulse normally.
REQ-018 ovtime, busy and done SHALL change only on clk rising edges or on reset.

Reset
REQ-019 rst=0 SHALL asynchronously force: state IDLE, ovtime=0, busy=0, done=0, counter=0, operand/quotient registers=0, and the fraction register=0.
REQ-020 Reset asserted mid-division SHALL abort the division with no ovtime update and no done pulse.
REQ-021 The first start after reset deassertion SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-022 With macro VTIME_FRAC_EN defined, the block SHALL:
- compute increment = floor((delta_t << 32) / sum_weight) as Q32.16 using 48 iterations, for a latency of 49 cycles;
- saturate the integer part to 0xFFFF (fraction to 0xFFFF when saturated);
- keep an internal 16-bit fraction accumulator whose carry-out adds 1 to ovtime.
REQ-023 Without VTIME_FRAC_EN, the fraction SHALL be discarded, with 32 iterations and 33-cycle latency per REQ-010..REQ-012.

Verification
REQ-024 The bench SHALL cover these scenarios (default build unless stated):
- Reset -> ovtime=0, busy=0, done=0; then start with delta_t=3, sum_weight=0x8000 -> busy high 33 cycles, done pulse, ovtime=6.
- Sequence 5/0xC000, 4/0x4000, 8/0xFFFF, each started when idle -> ovtime 12, 28, 36.
- start re-asserted each cycle while busy with other operands -> ignored, only the captured update applied.
- sum_weight=0 -> done after 33 cycles, ovtime unchanged; from ovtime=36, delta_t=0xFFFF with sum_weight=0x0001 -> saturated increment, ovtime=35 (wrap).
- rst asserted at cycle 10 of a division -> ovtime=0, no done; next start works normally.
- VTIME_FRAC_EN: two updates of 5/0xC000 -> ovtime=13 (vs 12 without), latency 49 cycles.
